// File: rtl/zstd_frame_header_parser.sv
// Zstandard frame-header parser: gathers magic/FHD/WD/DID/FCS from a byte stream, then decodes
// the fields and Window_Size and flags skippable or malformed frames.
module zstd_frame_header_parser #(
  parameter int unsigned IN_BYTES       = 2,
  parameter int unsigned MAX_WINDOW_LOG = 27
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [8*IN_BYTES-1:0] data_in_i,
  output logic                  hdr_valid_o,
  input  logic                  hdr_ready_i,
  output logic [1:0]            err_code_o,
  output logic                  is_skippable_o,
  output logic [31:0]           skip_size_o,
  output logic [7:0]            frame_header_descriptor_o,
  output logic [7:0]            window_descriptor_o,
  output logic [31:0]           dictionary_id_o,
  output logic [63:0]           frame_content_size_o,
  output logic [63:0]           window_size_o,
  output logic [7:0]            sizes_o,
  output logic [4:0]            header_len_o,
  output logic [3:0]            tail_bytes_o
);
  localparam int unsigned MaxHdr   = 18;
  localparam logic [5:0]  InBytes  = 6'(IN_BYTES);
  localparam logic [5:0]  MaxWl    = 6'(MAX_WINDOW_LOG);
  localparam logic [31:0] MagicStd = 32'hFD2FB528;
  localparam logic [27:0] MagicSkp = 28'h184D2A5;

  typedef enum logic [1:0] {StIdle, StCollect, StDecode, StDone} state_e;

  typedef struct packed {
    logic [1:0]  err;
    logic        skp;
    logic [31:0] ssz;
    logic [7:0]  fhd;
    logic [7:0]  wd;
    logic [31:0] did;
    logic [63:0] fcs;
    logic [63:0] ws;
    logic [7:0]  sizes;
    logic [4:0]  hlen;
    logic [3:0]  tail;
  } res_t;

  function automatic logic [5:0] did_len(input logic [1:0] code);
    logic [5:0] n;
    unique case (code)
      2'd0:    n = 6'd0;
      2'd1:    n = 6'd1;
      2'd2:    n = 6'd2;
      default: n = 6'd4;
    endcase
    return n;
  endfunction

  function automatic logic [5:0] fcs_len(input logic [1:0] code, input logic ss);
    logic [5:0] n;
    unique case (code)
      2'd0:    n = ss ? 6'd1 : 6'd0;
      2'd1:    n = 6'd2;
      2'd2:    n = 6'd4;
      default: n = 6'd8;
    endcase
    return n;
  endfunction

  state_e     state_q, state_d;
  logic [7:0] buf_q [MaxHdr];
  logic [7:0] buf_d [MaxHdr];
  logic [5:0] cnt_q, cnt_d;
  logic [4:0] len_q, len_d;
  logic [3:0] tail_q, tail_d;
  res_t       res_q, res_d;

  logic [7:0]  view [MaxHdr];
  logic [5:0]  avail, req_len, lane;
  logic [31:0] view_magic;
  logic        final_beat;

  // Stored bytes overlaid with the current beat, so magic/FHD arriving in this beat set L.
  always_comb begin
    avail = cnt_q + InBytes;
    lane  = '0;
    for (int j = 0; j < MaxHdr; j++) begin
      view[j] = buf_q[j];
      if (6'(j) >= cnt_q && 6'(j) < avail) begin
        lane    = 6'(j) - cnt_q;
        view[j] = 8'(data_in_i >> {lane, 3'b000});
      end
    end
    view_magic = {view[3], view[2], view[1], view[0]};
    req_len    = 6'd5;
    if (avail >= 6'd4) begin
      if (view_magic[31:4] == MagicSkp) begin
        req_len = 6'd8;
      end else if (view_magic != MagicStd) begin
        req_len = 6'd4;
      end else if (avail >= 6'd5) begin
        req_len = 6'd5 + {5'd0, ~view[4][5]} + did_len(view[4][1:0])
                + fcs_len(view[4][7:6], view[4][5]);
      end
    end
    final_beat = (avail >= req_len);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    tail_d     = tail_q;
    buf_d      = buf_q;
    in_ready_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StCollect;
          cnt_d   = '0;
        end
      end
      StCollect: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          for (int j = 0; j < MaxHdr; j++) begin
            if (6'(j) >= cnt_q && 6'(j) < avail && 6'(j) < req_len) buf_d[j] = view[j];
          end
          cnt_d = avail;
          if (final_beat) begin
            state_d = StDecode;
            len_d   = req_len[4:0];
            tail_d  = 4'(avail - req_len);
          end
        end
      end
      StDecode: state_d = StDone;
      StDone:   if (hdr_ready_i) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  logic [31:0] magic;
  logic        ss;
  logic [4:0]  off, idx;
  logic [5:0]  dn, fn, wl;
  logic [63:0] base;

  always_comb begin
    res_d      = '0;
    res_d.hlen = len_q;
    res_d.tail = tail_q;
    magic      = {buf_q[3], buf_q[2], buf_q[1], buf_q[0]};
    ss         = buf_q[4][5];
    off        = 5'd5;
    idx        = '0;
    dn         = did_len(buf_q[4][1:0]);
    fn         = fcs_len(buf_q[4][7:6], ss);
    wl         = '0;
    base       = '0;
    if (magic[31:4] == MagicSkp) begin
      res_d.skp = 1'b1;
      res_d.ssz = {buf_q[7], buf_q[6], buf_q[5], buf_q[4]};
    end else if (magic != MagicStd) begin
      res_d.err = 2'd1;
    end else begin
      res_d.fhd   = buf_q[4];
      res_d.sizes = {3'b000, ~ss, buf_q[4][1:0], buf_q[4][7:6]};
      if (!ss) begin
        res_d.wd = buf_q[5];
        off      = 5'd6;
      end
      for (int k = 0; k < 4; k++) begin
        idx = off + 5'(k);
        if (6'(k) < dn) res_d.did[8*k +: 8] = buf_q[idx];
      end
      off = off + dn[4:0];
      for (int k = 0; k < 8; k++) begin
        idx = off + 5'(k);
        if (6'(k) < fn) res_d.fcs[8*k +: 8] = buf_q[idx];
      end
      if (buf_q[4][7:6] == 2'd1) res_d.fcs = res_d.fcs + 64'd256;
      wl   = 6'd10 + {1'b0, res_d.wd[7:3]};
      base = 64'd1 << wl;
      res_d.ws = ss ? res_d.fcs : base + (base >> 3) * {61'd0, res_d.wd[2:0]};
      if (buf_q[4][3])           res_d.err = 2'd2;
      else if (!ss && wl > MaxWl) res_d.err = 2'd3;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      len_q   <= '0;
      tail_q  <= '0;
      res_q   <= '0;
      for (int j = 0; j < MaxHdr; j++) buf_q[j] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      tail_q  <= tail_d;
      buf_q   <= buf_d;
      if (state_q == StDecode) res_q <= res_d;
    end
  end

  assign hdr_valid_o               = (state_q == StDone);
  assign err_code_o                = res_q.err;
  assign is_skippable_o            = res_q.skp;
  assign skip_size_o               = res_q.ssz;
  assign frame_header_descriptor_o = res_q.fhd;
  assign window_descriptor_o       = res_q.wd;
  assign dictionary_id_o           = res_q.did;
  assign frame_content_size_o      = res_q.fcs;
  assign window_size_o             = res_q.ws;
  assign sizes_o                   = res_q.sizes;
  assign header_len_o              = res_q.hlen;
  assign tail_bytes_o              = res_q.tail;

endmodule

// File: tb/tb_zstd_frame_header_parser.sv
// Bench for zstd_frame_header_parser: three instances (IN_BYTES 2/4/8) driven from a vector table
// plus hand-written hold and mid-parse reset sequences.
module tb_zstd_frame_header_parser;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [2:0]       start, vld, hrdy, rdy, hv, skp;
  logic [2:0][63:0] din, fcs, ws;
  logic [2:0][1:0]  err;
  logic [2:0][31:0] ssz, did;
  logic [2:0][7:0]  fhd, wdo, sz;
  logic [2:0][4:0]  hl;
  logic [2:0][3:0]  tl;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned Ib = 2 << g;
    zstd_frame_header_parser #(.IN_BYTES(Ib), .MAX_WINDOW_LOG(27)) u_dut (
      .clk_i                    (clk),
      .reset_i                  (reset),
      .start_i                  (start[g]),
      .in_valid_i               (vld[g]),
      .in_ready_o               (rdy[g]),
      .data_in_i                (din[g][8*Ib-1:0]),
      .hdr_valid_o              (hv[g]),
      .hdr_ready_i              (hrdy[g]),
      .err_code_o               (err[g]),
      .is_skippable_o           (skp[g]),
      .skip_size_o              (ssz[g]),
      .frame_header_descriptor_o(fhd[g]),
      .window_descriptor_o      (wdo[g]),
      .dictionary_id_o          (did[g]),
      .frame_content_size_o     (fcs[g]),
      .window_size_o            (ws[g]),
      .sizes_o                  (sz[g]),
      .header_len_o             (hl[g]),
      .tail_bytes_o             (tl[g])
    );
  end

  typedef struct {
    int          inst;
    int          nbytes;
    bit          gap;
    int          hold;
    logic [191:0] data;
    logic [1:0]  err;
    logic        skp;
    logic [31:0] ssz;
    logic [7:0]  fhd;
    logic [7:0]  wd;
    logic [31:0] did;
    logic [63:0] fcs;
    logic [63:0] ws;
    logic [7:0]  sizes;
    int          hlen;
    int          tail;
  } vec_t;

  int passes = 0;
  int checks = 0;
  vec_t vecs [10];

  function automatic vec_t mk(input int inst, input int nbytes, input bit gap, input int hold,
                              input logic [191:0] data, input logic [1:0] e, input logic s,
                              input logic [31:0] ssize, input logic [7:0] f, input logic [7:0] w,
                              input logic [31:0] d, input logic [63:0] c, input logic [63:0] win,
                              input logic [7:0] szs, input int hlen, input int tail);
    vec_t v;
    v.inst = inst; v.nbytes = nbytes; v.gap = gap; v.hold = hold; v.data = data;
    v.err = e; v.skp = s; v.ssz = ssize; v.fhd = f; v.wd = w; v.did = d; v.fcs = c;
    v.ws = win; v.sizes = szs; v.hlen = hlen; v.tail = tail;
    return v;
  endfunction

  // Data is written as a byte list, first stream byte leftmost.
  function automatic logic [7:0] byte_at(input vec_t v, input int k);
    logic [191:0] s;
    s = v.data >> (8 * (v.nbytes - 1 - k));
    return s[7:0];
  endfunction

  function automatic logic [63:0] beat_data(input vec_t v, input int pos, input int ibn);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < ibn; i++) if (pos + i < v.nbytes) r[8*i +: 8] = byte_at(v, pos + i);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_results(input vec_t v, input string tag);
    int d = v.inst;
    chk({tag, " err_code"}, 64'(err[d]), 64'(v.err));
    chk({tag, " is_skippable"}, 64'(skp[d]), 64'(v.skp));
    chk({tag, " skip_size"}, 64'(ssz[d]), 64'(v.ssz));
    chk({tag, " fhd"}, 64'(fhd[d]), 64'(v.fhd));
    chk({tag, " window_descriptor"}, 64'(wdo[d]), 64'(v.wd));
    chk({tag, " dictionary_id"}, 64'(did[d]), 64'(v.did));
    chk({tag, " frame_content_size"}, fcs[d], v.fcs);
    chk({tag, " window_size"}, ws[d], v.ws);
    chk({tag, " sizes"}, 64'(sz[d]), 64'(v.sizes));
    chk({tag, " header_len"}, 64'(hl[d]), 64'(v.hlen));
    chk({tag, " tail_bytes"}, 64'(tl[d]), 64'(v.tail));
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int d = v.inst;
    int ibn = 2 << v.inst;
    int pos = 0;
    int beats = 0;
    bit go, acc, saw_rdy, unstable;
    @(negedge clk); start[d] = 1'b1;
    @(negedge clk); start[d] = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (beats > 0 && !rdy[d]) break;
      go     = !(v.gap && (cyc % 2 == 1));
      vld[d] = go;
      din[d] = beat_data(v, pos, ibn);
      acc    = go && rdy[d];
      @(negedge clk);
      if (acc) begin
        pos += ibn;
        beats++;
      end
    end
    vld[d] = 1'b0;
    chk({tag, " beats accepted"}, 64'(beats), 64'((v.hlen + ibn - 1) / ibn));
    chk({tag, " hdr_valid one cycle after final beat"}, 64'(hv[d]), 64'd0);
    @(negedge clk);
    chk({tag, " hdr_valid two cycles after final beat"}, 64'(hv[d]), 64'd1);
    check_results(v, tag);
    if (v.hold > 0) begin
      saw_rdy  = 1'b0;
      unstable = 1'b0;
      for (int i = 0; i < v.hold; i++) begin
        vld[d] = (i % 2 == 0);
        din[d] = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        if (rdy[d]) saw_rdy = 1'b1;
        if (!hv[d] || ws[d] !== v.ws || hl[d] !== 5'(v.hlen)) unstable = 1'b1;
      end
      vld[d] = 1'b0;
      chk({tag, " in_ready during hold"}, 64'(saw_rdy), 64'd0);
      chk({tag, " outputs unstable during hold"}, 64'(unstable), 64'd0);
      check_results(v, {tag, " after hold"});
    end
    hrdy[d]  = 1'b1;
    start[d] = (v.hold > 0);
    @(negedge clk);
    hrdy[d]  = 1'b0;
    start[d] = 1'b0;
    chk({tag, " hdr_valid after handshake"}, 64'(hv[d]), 64'd0);
    chk({tag, " in_ready after handshake"}, 64'(rdy[d]), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = '0; vld = '0; hrdy = '0; din = '0;
    vecs[0] = mk(0, 6, 0, 0, {8'h28, 8'hB5, 8'h2F, 8'hFD, 8'h00, 8'h58},
                 2'd0, 0, 0, 8'h00, 8'h58, 0, 0, 64'h20_0000, 8'h10, 6, 0);
    vecs[1] = mk(1, 12, 0, 0, {8'h28, 8'hB5, 8'h2F, 8'hFD, 8'h62, 8'h34, 8'h12, 8'h00, 8'h01,
                 8'hAA, 8'hBB, 8'hCC}, 2'd0, 0, 0, 8'h62, 8'h00, 32'h1234, 64'h200, 64'h200,
                 8'h09, 9, 3);
    vecs[2] = mk(2, 8, 0, 0, {8'h5A, 8'h2A, 8'h4D, 8'h18, 8'h10, 8'h00, 8'h00, 8'h00},
                 2'd0, 1, 32'h10, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8, 0);
    vecs[3] = mk(0, 4, 0, 0, {8'h28, 8'hB5, 8'h2F, 8'hFC},
                 2'd1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 4, 0);
    vecs[4] = mk(0, 6, 0, 0, {8'h28, 8'hB5, 8'h2F, 8'hFD, 8'h08, 8'h00},
                 2'd2, 0, 0, 8'h08, 8'h00, 0, 0, 64'h400, 8'h10, 6, 0);
    vecs[5] = mk(0, 6, 0, 0, {8'h28, 8'hB5, 8'h2F, 8'hFD, 8'h00, 8'h90},
                 2'd3, 0, 0, 8'h00, 8'h90, 0, 0, 64'h1000_0000, 8'h10, 6, 0);
    vecs[6] = mk(2, 24, 0, 0, {8'h28, 8'hB5, 8'h2F, 8'hFD, 8'hC3, 8'h4B, 8'h78, 8'h56, 8'h34,
                 8'h12, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 48'hEEEE_EEEE_EEEE},
                 2'd0, 0, 0, 8'hC3, 8'h4B, 32'h1234_5678, 64'h0807_0605_0403_0201, 64'hB_0000,
                 8'h1F, 18, 6);
    vecs[7] = mk(1, 8, 1, 0, {8'h28, 8'hB5, 8'h2F, 8'hFD, 8'h20, 8'hFF, 8'h00, 8'h00},
                 2'd0, 0, 0, 8'h20, 8'h00, 0, 64'hFF, 64'hFF, 8'h00, 6, 2);
    vecs[8] = mk(0, 8, 1, 0, {8'h50, 8'h2A, 8'h4D, 8'h18, 8'h04, 8'h03, 8'h02, 8'h01},
                 2'd0, 1, 32'h0102_0304, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8, 0);
    vecs[9] = mk(0, 6, 0, 10, {8'h28, 8'hB5, 8'h2F, 8'hFD, 8'h00, 8'hFF},
                 2'd3, 0, 0, 8'h00, 8'hFF, 0, 0, 64'h0000_03C0_0000_0000, 8'h10, 6, 0);

    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset in_ready[%0d]", d), 64'(rdy[d]), 64'd0);
      chk($sformatf("reset hdr_valid[%0d]", d), 64'(hv[d]), 64'd0);
      chk($sformatf("reset window_size[%0d]", d), ws[d], 64'd0);
      chk($sformatf("reset header_len[%0d]", d), 64'(hl[d]), 64'd0);
    end

    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Abort a parse after one accepted beat, then the same frame must decode cleanly.
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0; vld[0] = 1'b1; din[0] = 64'hB528;
    @(negedge clk); vld[0] = 1'b0; reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("midreset in_ready", 64'(rdy[0]), 64'd0);
    chk("midreset hdr_valid", 64'(hv[0]), 64'd0);
    chk("midreset window_size", ws[0], 64'd0);
    chk("midreset err_code", 64'(err[0]), 64'd0);
    run_vec(vecs[0], "after reset");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
